// File: rtl/dac_din_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dac_din_buffer
// Purpose  : User-to-JESD TX word buffer. Discards input until a sync word,
//            pre-fills a small FIFO to PRIME_LEVEL, then streams words under
//            tx_ready backpressure. Overflow/underflow are reported through
//            sticky flags and a saturating underflow counter.
// Revision : 1.0  initial release
// ============================================================================
module dac_din_buffer #(
   parameter int DATA_W      = 512,
   parameter int DEPTH       = 16,
   parameter int PRIME_LEVEL = 8
) (
   input  logic                     link_clk,
   input  logic                     link_areset_n,
   input  logic                     enable,
   input  logic                     clear_status,
   input  logic [DATA_W-1:0]        din,
   input  logic                     din_vld,
   input  logic                     din_sync,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     din_overflow,
   output logic                     din_underflow,
   output logic [15:0]              underflow_cnt,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;

   logic                fifo_empty;
   logic                fifo_full;
   logic                do_push;
   logic                do_pop;
   logic                ovf_evt;
   logic                udf_evt;

   assign fill_level = count;

   // Push/pop qualification and event detection from the registered count
   always_comb begin
      fifo_empty = (count == '0);
      fifo_full  = (count == DEPTH_C);
      do_pop     = enable && (state == ST_RUN) && tx_ready && !fifo_empty;
      udf_evt    = enable && (state == ST_RUN) && tx_ready && fifo_empty;
      do_push    = 1'b0;
      ovf_evt    = 1'b0;
      if (state == ST_IDLE) begin
         // FIFO is always empty here, so the sync word can never be dropped
         do_push = enable && din_vld && din_sync;
      end else begin
         // A full FIFO still accepts a word when the head leaves this cycle
         do_push = enable && din_vld && (!fifo_full || do_pop);
         ovf_evt = enable && din_vld && fifo_full && !do_pop;
      end
   end

   // FIFO storage write port (contents are don't-care until pushed)
   always_ff @(posedge link_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking; disable flushes the FIFO
   always_ff @(posedge link_clk) begin
      if (!link_areset_n || !enable) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end

   // Stream control FSM with registered tx_valid/tx_data
   always_ff @(posedge link_clk) begin
      if (!link_areset_n || !enable) begin
         state    <= ST_IDLE;
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_valid <= 1'b0;
               tx_data  <= '0;
               if (din_vld && din_sync) begin
                  state <= ST_PRIME;
               end
            end
            ST_PRIME: begin
               if (count >= PRIME_C) begin
                  state    <= ST_RUN;
                  tx_valid <= 1'b1;
               end
            end
            ST_RUN: begin
               if (tx_ready) begin
                  if (!fifo_empty) begin
                     tx_data <= mem[rd_ptr];
                  end else begin
                     // Starved: emit zero and re-prime, keeping any new input
                     tx_data  <= '0;
                     tx_valid <= 1'b0;
                     state    <= ST_PRIME;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               tx_valid <= 1'b0;
               tx_data  <= '0;
            end
         endcase
      end
   end

   // Sticky status; a new event in the same cycle beats clear_status
   always_ff @(posedge link_clk) begin
      if (!link_areset_n) begin
         din_overflow  <= 1'b0;
         din_underflow <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         if (ovf_evt) begin
            din_overflow <= 1'b1;
         end else if (clear_status) begin
            din_overflow <= 1'b0;
         end
         if (udf_evt) begin
            din_underflow <= 1'b1;
            if (clear_status) begin
               underflow_cnt <= 16'd1;
            end else if (underflow_cnt != 16'hFFFF) begin
               underflow_cnt <= underflow_cnt + 16'd1;
            end
         end else if (clear_status) begin
            din_underflow <= 1'b0;
            underflow_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dac_din_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_din_buffer
// Purpose  : Self-checking bench for dac_din_buffer using a queue-based
//            reference model plus directed scenarios and random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_dac_din_buffer;

   localparam int DW      = 512;
   localparam int DEPTH   = 16;
   localparam int PRIME   = 8;
   localparam int M_IDLE  = 0;
   localparam int M_PRIME = 1;
   localparam int M_RUN   = 2;

   logic           clk;
   logic           rst_n;
   logic           enable;
   logic           clear_status;
   logic [DW-1:0]  din;
   logic           din_vld;
   logic           din_sync;
   logic [DW-1:0]  tx_data;
   logic           tx_valid;
   logic           tx_ready;
   logic           din_overflow;
   logic           din_underflow;
   logic [15:0]    underflow_cnt;
   logic [4:0]     fill_level;

   dac_din_buffer #(
      .DATA_W      (DW),
      .DEPTH       (DEPTH),
      .PRIME_LEVEL (PRIME)
   ) dut (
      .link_clk      (clk),
      .link_areset_n (rst_n),
      .enable        (enable),
      .clear_status  (clear_status),
      .din           (din),
      .din_vld       (din_vld),
      .din_sync      (din_sync),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .din_overflow  (din_overflow),
      .din_underflow (din_underflow),
      .underflow_cnt (underflow_cnt),
      .fill_level    (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: stream mode, a word queue and the visible status
   int             m_mode;
   logic [DW-1:0]  m_q [$];
   logic [DW-1:0]  m_tx_data;
   bit             m_tx_valid;
   bit             m_ovf;
   bit             m_udf;
   int             m_ucnt;

   int             n_checks;
   int             n_err;
   string          phase;
   int             first_valid;
   int             clr_issued;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int sz;
      bit popped;
      bit ov;
      bit uf;
      if (!rst_n) begin
         m_mode = M_IDLE;
         m_q.delete();
         m_tx_data  = '0;
         m_tx_valid = 1'b0;
         m_ovf      = 1'b0;
         m_udf      = 1'b0;
         m_ucnt     = 0;
         return;
      end
      sz = m_q.size();
      popped = 1'b0;
      ov = 1'b0;
      uf = 1'b0;
      if (!enable) begin
         m_mode = M_IDLE;
         m_q.delete();
         m_tx_data = '0;
      end else if (m_mode == M_IDLE) begin
         if (din_vld && din_sync) begin
            m_q.push_back(din);
            m_mode = M_PRIME;
         end
      end else if (m_mode == M_PRIME) begin
         if (din_vld) begin
            if (sz < DEPTH) m_q.push_back(din);
            else ov = 1'b1;
         end
         if (sz >= PRIME) m_mode = M_RUN;
      end else begin
         if (tx_ready) begin
            if (sz > 0) begin
               m_tx_data = m_q.pop_front();
               popped = 1'b1;
            end else begin
               m_tx_data = '0;
               uf = 1'b1;
               m_mode = M_PRIME;
            end
         end
         if (din_vld) begin
            if (sz < DEPTH || popped) m_q.push_back(din);
            else ov = 1'b1;
         end
      end
      m_tx_valid = (m_mode == M_RUN);
      if (ov) m_ovf = 1'b1;
      else if (clear_status) m_ovf = 1'b0;
      if (uf) begin
         m_udf = 1'b1;
         if (clear_status) m_ucnt = 1;
         else if (m_ucnt < 65535) m_ucnt = m_ucnt + 1;
      end else if (clear_status) begin
         m_udf = 1'b0;
         m_ucnt = 0;
      end
   endtask

   task automatic compare_all();
      check("tx_valid", DW'(tx_valid), DW'(m_tx_valid));
      check("tx_data", tx_data, m_tx_data);
      check("fill", DW'(fill_level), DW'(m_q.size()));
      check("ovf", DW'(din_overflow), DW'(m_ovf));
      check("udf", DW'(din_underflow), DW'(m_udf));
      check("ucnt", DW'(underflow_cnt), DW'(m_ucnt));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit en, input bit vld, input bit sy,
                        input logic [DW-1:0] d, input bit rdy, input bit clr);
      enable       = en;
      din_vld      = vld;
      din_sync     = sy;
      din          = d;
      tx_ready     = rdy;
      clear_status = clr;
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, '0, 0, 0);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_err = 0;
      clr_issued = 0;
      rst_n = 1'b0;
      drive(0, 0, 0, '0, 0, 0);

      // Reset values
      phase = "reset";
      apply_reset();
      check("tx_valid0", DW'(tx_valid), DW'(0));
      check("tx_data0", tx_data, DW'(0));
      check("fill0", DW'(fill_level), DW'(0));
      check("ucnt0", DW'(underflow_cnt), DW'(0));

      // Basic stream: words 0..19, sync on word 0, tx_ready held high
      phase = "basic";
      apply_reset();
      first_valid = -1;
      for (int i = 0; i < 40; i++) begin
         drive(1, i < 20, i == 0, DW'(i), 1, 0);
         step();
         if (tx_valid && first_valid < 0) first_valid = i;
         if (i >= 9 && i <= 28) check("seq", tx_data, DW'(i - 9));
      end
      check("latency", DW'(first_valid + 1), DW'(PRIME + 1));
      check("udf_end", DW'(din_underflow), DW'(1));
      check("ucnt_end", DW'(underflow_cnt), DW'(1));
      check("txd_end", tx_data, DW'(0));
      check("txv_end", DW'(tx_valid), DW'(0));

      // Words before the sync word are discarded
      phase = "presync";
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, DW'(32'h100 + i), 1, 0);
         step();
         check("fill_pre", DW'(fill_level), DW'(0));
      end
      drive(1, 1, 1, DW'(32'hA5), 1, 0);
      step();
      check("fill_sync", DW'(fill_level), DW'(1));
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, i == 1, DW'(32'h180 + i), 1, 0);
         step();
         check("fill_post", DW'(fill_level), DW'(i + 2));
      end
      check("ovf", DW'(din_overflow), DW'(0));
      for (int j = 0; j < 10; j++) begin
         drive(1, 1, 0, DW'(32'h200 + j), 1, 0);
         step();
         if (j == 5) check("first_out", tx_data, DW'(32'hA5));
      end

      // Overflow: fill past DEPTH with tx_ready low, then drain
      phase = "overflow";
      apply_reset();
      for (int i = 0; i < 18; i++) begin
         drive(1, 1, i == 0, DW'(32'h300 + i), 0, 0);
         step();
      end
      check("fill_full", DW'(fill_level), DW'(DEPTH));
      check("ovf_set", DW'(din_overflow), DW'(1));
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 0, '0, 1, 0);
         step();
         if (i < 16) check("drain", tx_data, DW'(32'h300 + i));
      end

      // Full FIFO with simultaneous push and pop across pointer wrap
      phase = "fullpp";
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, i == 0, DW'(32'h400 + i), 0, 0);
         step();
      end
      for (int i = 0; i < 40; i++) begin
         drive(1, 1, 0, DW'(32'h410 + i), 1, 0);
         step();
         check("fill16", DW'(fill_level), DW'(DEPTH));
         check("order", tx_data, DW'(32'h400 + i));
      end
      check("no_ovf", DW'(din_overflow), DW'(0));

      // Disable mid-RUN, then clear coincident with an underflow
      phase = "disclr";
      apply_reset();
      for (int i = 0; i < 25; i++) begin
         drive(1, i < 10, i == 0, DW'(32'h500 + i), 1, 0);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, i == 0, DW'(32'h600 + i), 0, 0);
         step();
      end
      check("run_before", DW'(tx_valid), DW'(1));
      drive(0, 0, 0, '0, 0, 0);
      step();
      check("dis_txv", DW'(tx_valid), DW'(0));
      check("dis_fill", DW'(fill_level), DW'(0));
      check("dis_udf", DW'(din_underflow), DW'(1));
      check("dis_ucnt", DW'(underflow_cnt), DW'(1));
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, i == 0, DW'(32'h700 + i), 0, 0);
         step();
      end
      for (int i = 0; i < 15; i++) begin
         drive(1, 0, 0, '0, 1, (m_mode == M_RUN) && (m_q.size() == 0));
         if (clear_status) clr_issued++;
         step();
      end
      check("clr_issued", DW'(clr_issued), DW'(1));
      check("clr_udf", DW'(din_underflow), DW'(1));
      check("clr_ucnt", DW'(underflow_cnt), DW'(1));
      drive(1, 0, 0, '0, 0, 1);
      step();
      check("clr_udf0", DW'(din_underflow), DW'(0));
      check("clr_ucnt0", DW'(underflow_cnt), DW'(0));

      // Reset while streaming with 10 words stored
      phase = "midreset";
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, i == 0, DW'(32'h800 + i), 0, 0);
         step();
      end
      check("fill10", DW'(fill_level), DW'(10));
      check("run10", DW'(tx_valid), DW'(1));
      rst_n = 1'b0;
      drive(1, 1, 0, rand_word(), 1, 1);
      step();
      rst_n = 1'b1;
      check("r_txv", DW'(tx_valid), DW'(0));
      check("r_txd", tx_data, DW'(0));
      check("r_fill", DW'(fill_level), DW'(0));
      check("r_ovf", DW'(din_overflow), DW'(0));
      check("r_udf", DW'(din_underflow), DW'(0));

      // Randomized traffic against the model
      phase = "random";
      apply_reset();
      for (int i = 0; i < 2000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         drive($urandom_range(0, 99) < 96,
               $urandom_range(0, 99) < 75,
               $urandom_range(0, 99) < 10,
               rand_word(),
               $urandom_range(0, 99) < 55,
               $urandom_range(0, 99) < 3);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
